mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of requesting channels (range 1..8).
REQ-002 SHALL have parameter RR_MODE, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority with lowest index winning.
REQ-003 SHALL have parameter TIMEOUT, default 0, bus-wait limit in cycles (0 = disabled, otherwise 2..65535).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ch_valid  in  CHANNELS  per-channel request; held with payload until ch_ready.
REQ-007 ch_instr  in  CHANNELS  per-channel instruction-fetch flag.
REQ-008 ch_addr / ch_wdata  in  32*CHANNELS each  packed address and write data; channel i at bits [32i+31:32i].
REQ-009 ch_wstrb  in  4*CHANNELS  packed byte strobes; all zero means read.
REQ-010 ch_ready  out  CHANNELS  one-hot completion pulse.
REQ-011 ch_err  out  CHANNELS  one-hot timeout pulse, coincident with ch_ready.
REQ-012 ch_rdata  out  32  read data for the channel currently pulsing ch_ready.
REQ-013 mem_valid, mem_instr  out  1 each; mem_addr, mem_wdata  out  32 each; mem_wstrb  out  4; mem_ready  in  1; mem_rdata  in  32  downstream port, picorv32 native protocol.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-015 IDLE: when any ch_valid is high, SHALL select one winner, latch its instr/addr/wdata/wstrb into output registers, set mem_valid=1 and enter BUSY on the same edge; mem_valid therefore rises one cycle after ch_valid is sampled.
REQ-016 RR_MODE=1: search SHALL start at pointer rr_ptr and proceed upward, wrapping modulo CHANNELS; on every grant, rr_ptr becomes (grant+1) mod CHANNELS.
REQ-017 RR_MODE=0: lowest-index valid channel SHALL win; rr_ptr stays unused at 0.
REQ-018 BUSY: mem_valid, mem_instr, mem_addr, mem_wdata and mem_wstrb SHALL be held constant until the cycle mem_ready=1 is sampled.
REQ-019 BUSY with mem_ready=1: SHALL clear mem_valid, register mem_rdata into ch_rdata, set ch_ready[grant]=1 and enter DONE; completion is one cycle after mem_ready.
REQ-020 DONE: ch_ready/ch_err SHALL be high for exactly this cycle; no grant is made in DONE; SHALL return to IDLE next edge.
REQ-021 Consequence of REQ-020: the minimum inter-grant gap is 3 cycles, and a channel still driving ch_valid in its ready cycle is not regranted that cycle.
REQ-022 ch_rdata SHALL hold its last value outside DONE and SHALL be updated for write completions as well, capturing the mem_rdata value present.
REQ-023 TIMEOUT>0: a 16-bit wait counter SHALL clear on entry to BUSY and increment on each BUSY cycle without mem_ready.
REQ-024 Timeout trigger: when the wait counter equals TIMEOUT-1 and mem_ready=0, SHALL clear mem_valid, set ch_rdata=0, pulse ch_ready[grant] and ch_err[grant], and enter DONE.
REQ-025 Timeout takes priority only when mem_ready=0; mem_ready=1 on the final cycle SHALL complete normally with ch_err=0.
REQ-026 Dropping ch_valid[grant] during BUSY SHALL be ignored; the transaction completes and ch_ready still pulses.
REQ-027 ch_valid on non-granted channels SHALL have no effect until the next IDLE evaluation.

Reset
REQ-028 On reset assertion, SHALL immediately drive state=IDLE, rr_ptr=0, wait counter=0, and all outputs to 0 (mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, ch_ready, ch_err, ch_rdata).
REQ-029 Reset mid-BUSY SHALL abandon the transaction with no ch_ready pulse; first grant after release SHALL occur no earlier than the first rising edge with reset low.

Verification
REQ-030 CHANNELS=2, RR_MODE=1: ch_valid=2'b11 held continuously, mem_ready returned 1 cycle after each mem_valid -> grants alternate 0,1,0,1 with ch_ready pulses 4 cycles apart.
REQ-031 RR_MODE=0, ch_valid=2'b11 held -> channel 0 granted on every grant; channel 1 granted only after ch_valid[0] drops.
REQ-032 Single read ch0 addr=0x100, mem_ready at BUSY cycle 3 with mem_rdata=0xDEADBEEF -> ch_rdata=0xDEADBEEF and ch_ready=2'b01 on the following cycle; mem_addr stable throughout BUSY.
REQ-033 TIMEOUT=4, mem_ready never asserted -> mem_valid high for exactly 4 cycles, then ch_ready and ch_err pulse together with ch_rdata=0.
REQ-034 Reset pulsed during BUSY -> all outputs 0 asynchronously and no ch_ready pulse; after release, rr_ptr=0 and channel 0 wins a 2'b11 request.
REQ-035 Write ch1 with wstrb=4'b0011, wdata=0x12345678 -> mem_wstrb=4'b0011, mem_wdata=0x12345678 and mem_instr=ch_instr[1] for the whole BUSY phase.

Source files
------------

// File: rtl/mem_port_if.sv
// Bundle between the requesting channels, the arbiter and the downstream picorv32-style memory port.
interface mem_port_if #(
    parameter int unsigned CHANNELS = 2
);
    logic [CHANNELS-1:0]    ch_valid;
    logic [CHANNELS-1:0]    ch_instr;
    logic [32*CHANNELS-1:0] ch_addr;
    logic [32*CHANNELS-1:0] ch_wdata;
    logic [4*CHANNELS-1:0]  ch_wstrb;
    logic [CHANNELS-1:0]    ch_ready;
    logic [CHANNELS-1:0]    ch_err;
    logic [31:0]            ch_rdata;

    logic                   mem_valid;
    logic                   mem_instr;
    logic [31:0]            mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_wstrb;
    logic                   mem_ready;
    logic [31:0]            mem_rdata;

    // Arbiter side: serves the channels, drives the memory port.
    modport slave (
        input  ch_valid, ch_instr, ch_addr, ch_wdata, ch_wstrb,
        output ch_ready, ch_err, ch_rdata,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    // Environment side: channels plus the memory responder.
    modport master (
        output ch_valid, ch_instr, ch_addr, ch_wdata, ch_wstrb,
        input  ch_ready, ch_err, ch_rdata,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter onto a single picorv32 native memory port, round-robin or fixed priority,
// with an optional bus-wait timeout that completes the transaction with an error pulse.
module mem_port_arbiter #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned RR_MODE  = 1,
    parameter int unsigned TIMEOUT  = 0
) (
    input  logic     clk,
    input  logic     reset,
    mem_port_if.slave bus
);
    localparam int unsigned PW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  grant;
    logic [15:0]    wait_cnt;

    logic           any_c;
    logic [PW-1:0]  pick_c;
    logic [PW-1:0]  next_ptr_c;
    logic           pick_instr_c;
    logic [31:0]    pick_addr_c;
    logic [31:0]    pick_wdata_c;
    logic [3:0]     pick_wstrb_c;

    // Winner search: start at rr_ptr (always 0 in fixed-priority mode) and walk upward with wrap.
    always_comb begin
        int unsigned idx;
        int unsigned start;
        any_c        = 1'b0;
        pick_c       = '0;
        idx          = 0;
        start        = (RR_MODE != 0) ? 32'(rr_ptr) : 32'd0;
        pick_instr_c = 1'b0;
        pick_addr_c  = '0;
        pick_wdata_c = '0;
        pick_wstrb_c = '0;
        for (int unsigned off = 0; off < CHANNELS; off++) begin
            idx = start + off;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!any_c && bus.ch_valid[idx]) begin
                any_c  = 1'b1;
                pick_c = PW'(idx);
            end
        end
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (pick_c == PW'(i)) begin
                pick_instr_c = bus.ch_instr[i];
                pick_addr_c  = bus.ch_addr[32*i +: 32];
                pick_wdata_c = bus.ch_wdata[32*i +: 32];
                pick_wstrb_c = bus.ch_wstrb[4*i +: 4];
            end
        end
        next_ptr_c = (32'(pick_c) == CHANNELS - 1) ? '0 : PW'(32'(pick_c) + 32'd1);
    end

    // Transaction FSM; ch_ready/ch_err are single-cycle pulses valid only in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            wait_cnt      <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_instr <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.ch_ready  <= '0;
            bus.ch_err    <= '0;
            bus.ch_rdata  <= '0;
        end else begin
            bus.ch_ready <= '0;
            bus.ch_err   <= '0;
            unique case (state)
                IDLE: begin
                    if (any_c) begin
                        grant         <= pick_c;
                        bus.mem_valid <= 1'b1;
                        bus.mem_instr <= pick_instr_c;
                        bus.mem_addr  <= pick_addr_c;
                        bus.mem_wdata <= pick_wdata_c;
                        bus.mem_wstrb <= pick_wstrb_c;
                        wait_cnt      <= '0;
                        if (RR_MODE != 0) begin
                            rr_ptr <= next_ptr_c;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.ch_rdata  <= bus.mem_rdata;
                        bus.ch_ready  <= CHANNELS'(1) << grant;
                        state         <= DONE;
                    end else if (TO_EN && (wait_cnt == TO_LAST)) begin
                        bus.mem_valid <= 1'b0;
                        bus.ch_rdata  <= '0;
                        bus.ch_ready  <= CHANNELS'(1) << grant;
                        bus.ch_err    <= CHANNELS'(1) << grant;
                        state         <= DONE;
                    end else if (TO_EN) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
